// File: rtl/shift_rr_arbiter.sv
// Four-way round-robin arbiter that shares one 8-bit rotating shifter.
// Each winner's operands are latched at grant. The result is registered and tagged with the winner's index.

module shift_rr_rotator #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic [DW-1:0] a_i,
   input  logic [AW-1:0] amt_i,
   input  logic          dir_i,
   output logic [DW-1:0] y_o
);
   // DW is 2**AW, so the AW-bit index arithmetic wraps mod DW.
   for (genvar k = 0; k < DW; k++) begin : g_bit
      logic [AW-1:0] src;
      assign src    = dir_i ? (AW'(k) + amt_i) : (AW'(k) - amt_i);
      assign y_o[k] = a_i[src];
   end
endmodule

module shift_rr_arbiter #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    req,
   input  logic [4*DW-1:0] a_bus,
   input  logic [4*AW-1:0] amt_bus,
   input  logic [3:0]    dir,
   output logic [3:0]    grant,
   output logic          busy,
   output logic [DW-1:0] y,
   output logic          y_valid,
   output logic [1:0]    y_id
);
   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [DW-1:0] a_q, a_d;
   logic [AW-1:0] amt_q, amt_d;
   logic          dir_q, dir_d;
   logic [1:0]    id_q, id_d;
   logic [3:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] y_q, y_d;
   logic          y_valid_q, y_valid_d;
   logic [1:0]    y_id_q, y_id_d;

   logic [DW-1:0] a_arr   [4];
   logic [AW-1:0] amt_arr [4];
   logic [1:0]    win, idx;
   logic          found;
   logic [DW-1:0] rot;

   for (genvar i = 0; i < 4; i++) begin : g_unpack
      assign a_arr[i]   = a_bus[i*DW +: DW];
      assign amt_arr[i] = amt_bus[i*AW +: AW];
   end

   // Search starts at ptr and takes the first requester set at or after it.
   always_comb begin
      win   = ptr_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   shift_rr_rotator #(.DW(DW), .AW(AW)) u_rot (
      .a_i   (a_q),
      .amt_i (amt_q),
      .dir_i (dir_q),
      .y_o   (rot)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      a_d       = a_q;
      amt_d     = amt_q;
      dir_d     = dir_q;
      id_d      = id_q;
      grant_d   = 4'b0000;
      busy_d    = 1'b0;
      y_d       = y_q;
      y_valid_d = 1'b0;
      y_id_d    = y_id_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               a_d     = a_arr[win];
               amt_d   = amt_arr[win];
               dir_d   = dir[win];
               id_d    = win;
               grant_d = 4'b0001 << win;
               ptr_d   = win + 2'd1;
               busy_d  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            y_d       = rot;
            y_id_d    = id_q;
            y_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         a_q       <= '0;
         amt_q     <= '0;
         dir_q     <= 1'b0;
         id_q      <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         y_id_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         a_q       <= a_d;
         amt_q     <= amt_d;
         dir_q     <= dir_d;
         id_q      <= id_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         y_id_q    <= y_id_d;
      end
   end

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign y_id    = y_id_q;
endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Scoreboard bench for shift_rr_arbiter: expected grants/results are queued at issue time.
// A negedge monitor pops and compares them.

module tb_shift_rr_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] a_bus;
   logic [11:0] amt_bus;
   logic [3:0]  dir;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  y;
   logic        y_valid;
   logic [1:0]  y_id;

   int checks = 0;
   int errors = 0;
   logic [3:0] gq [$];
   logic [9:0] yq [$];

   shift_rr_arbiter #(.DW(8), .AW(3)) dut (
      .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .amt_bus(amt_bus),
      .dir(dir), .grant(grant), .busy(busy), .y(y), .y_valid(y_valid), .y_id(y_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every grant and every result pulse must match the head of its queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (grant != 4'b0000) begin
            if (gq.size() == 0) chk("unexpected_grant", {28'd0, grant}, 32'd0);
            else chk("sb_grant", {28'd0, grant}, {28'd0, gq.pop_front()});
         end
         if (y_valid) begin
            if (yq.size() == 0) chk("unexpected_y_valid", {22'd0, y_id, y}, 32'hFFFF);
            else chk("sb_result", {22'd0, y_id, y}, {22'd0, yq.pop_front()});
         end
      end
   end

   task automatic set_op(input int id, input logic [7:0] a, input logic [2:0] amt, input logic d);
      a_bus[id*8 +: 8]   = a;
      amt_bus[id*3 +: 3] = amt;
      dir[id]            = d;
   endtask

   task automatic single(input int id, input logic [7:0] a, input logic [2:0] amt,
                         input logic d, input logic [7:0] ey);
      @(posedge clk); #1;
      set_op(id, a, amt, d);
      req[id] = 1'b1;
      gq.push_back(4'b0001 << id);
      yq.push_back({2'(id), ey});
      @(posedge clk); #1;
      chk("grant_cycle", {28'd0, grant}, {28'd0, 4'b0001 << id});
      chk("busy_exec", {31'd0, busy}, 32'd1);
      req[id] = 1'b0;
      @(posedge clk); #1;
      chk("yv_latency", {31'd0, y_valid}, 32'd1);
      chk("grant_off", {28'd0, grant}, 32'd0);
      @(posedge clk); #1;
      chk("yv_drop", {31'd0, y_valid}, 32'd0);
   endtask

   initial begin
      logic [3:0] fair_exp [5];
      fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset = 1'b1; req = '0; a_bus = '0; amt_bus = '0; dir = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_grant", {28'd0, grant}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_y", {24'd0, y}, 32'd0);
      chk("rst_yv", {31'd0, y_valid}, 32'd0);
      chk("rst_yid", {30'd0, y_id}, 32'd0);

      // Reset during EXEC: the in-flight result must never appear.
      @(posedge clk); #1;
      set_op(0, 8'hFF, 3'd1, 1'b0);
      req = 4'b0001;
      gq.push_back(4'b0001);
      @(posedge clk); #1;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      req = 4'b0000;
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_grant", {28'd0, grant}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_y", {24'd0, y}, 32'd0);
      chk("mid_rst_yv", {31'd0, y_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      // Fairness from ptr=0 with all requests held.
      #1;
      set_op(0, 8'h01, 3'd1, 1'b0);
      set_op(1, 8'h80, 3'd1, 1'b1);
      set_op(2, 8'h0F, 3'd2, 1'b0);
      set_op(3, 8'h3C, 3'd2, 1'b1);
      req = 4'b1111;
      foreach (fair_exp[n]) gq.push_back(fair_exp[n]);
      yq.push_back({2'd0, 8'h02}); yq.push_back({2'd1, 8'h40});
      yq.push_back({2'd2, 8'h3C}); yq.push_back({2'd3, 8'h0F});
      yq.push_back({2'd0, 8'h02});
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         chk("fair_grant", {28'd0, grant}, {28'd0, fair_exp[n]});
         if (n == 4) req = 4'b0000;
         @(posedge clk); #1;
         chk("fair_yv", {31'd0, y_valid}, 32'd1);
         chk("fair_gap", {28'd0, grant}, 32'd0);
      end

      single(0, 8'h81, 3'd1, 1'b0, 8'h03);
      single(2, 8'h81, 3'd1, 1'b1, 8'hC0);
      single(1, 8'hA5, 3'd0, 1'b0, 8'hA5);

      // ptr=2, req=0011: index 0 wins, then ptr=1 lets index 1 win.
      @(posedge clk); #1;
      set_op(0, 8'h12, 3'd4, 1'b0);
      set_op(1, 8'h34, 3'd4, 1'b1);
      req = 4'b0011;
      gq.push_back(4'b0001); gq.push_back(4'b0010);
      yq.push_back({2'd0, 8'h21}); yq.push_back({2'd1, 8'h43});
      @(posedge clk); #1;
      chk("prio_grant0", {28'd0, grant}, 32'h1);
      req = 4'b0010;
      @(posedge clk); #1;
      chk("prio_yv0", {31'd0, y_valid}, 32'd1);
      @(posedge clk); #1;
      chk("prio_grant1", {28'd0, grant}, 32'h2);
      req = 4'b0000;
      @(posedge clk); #1;
      chk("prio_yv1", {31'd0, y_valid}, 32'd1);

      // Held req on 3 with an operand change during EXEC.
      @(posedge clk); #1;
      set_op(3, 8'hF0, 3'd4, 1'b0);
      req = 4'b1000;
      gq.push_back(4'b1000); gq.push_back(4'b1000);
      yq.push_back({2'd3, 8'h0F}); yq.push_back({2'd3, 8'h0F});
      @(posedge clk); #1;
      chk("held_grant0", {28'd0, grant}, 32'h8);
      a_bus[31:24] = 8'h55;
      @(posedge clk); #1;
      chk("held_yv0", {31'd0, y_valid}, 32'd1);
      a_bus[31:24] = 8'hF0;
      @(posedge clk); #1;
      chk("held_grant1", {28'd0, grant}, 32'h8);
      req = 4'b0000;
      @(posedge clk); #1;
      chk("held_yv1", {31'd0, y_valid}, 32'd1);

      repeat (4) @(posedge clk);
      #1;
      chk("grant_queue_drained", gq.size(), 32'd0);
      chk("result_queue_drained", yq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
